// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT sequencer: walks stage/butterfly counters, reads operand
// pairs and twiddles, drives the butterfly unit and writes the results back in place.
module fft_bfly_sched #(
  parameter int N_LOG2 = 8,
  parameter int DATA_W = 24,
  parameter int TW_W   = 16,
  parameter int BF_TMO = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [N_LOG2-1:0]     stage,
  output logic [N_LOG2-1:0]     ram_addr_a,
  output logic [N_LOG2-1:0]     ram_addr_b,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [2*DATA_W-1:0]   ram_rd_a,
  input  logic [2*DATA_W-1:0]   ram_rd_b,
  output logic [2*DATA_W-1:0]   ram_wd_a,
  output logic [2*DATA_W-1:0]   ram_wd_b,
  output logic [N_LOG2-2:0]     tw_addr,
  input  logic [2*TW_W-1:0]     tw_rd,
  output logic                  bf_en,
  output logic [DATA_W-1:0]     bf_a_re,
  output logic [DATA_W-1:0]     bf_a_im,
  output logic [DATA_W-1:0]     bf_b_re,
  output logic [DATA_W-1:0]     bf_b_im,
  output logic [TW_W-1:0]       bf_c_re,
  output logic [TW_W-1:0]       bf_c_im,
  input  logic [DATA_W-1:0]     bf_outa_re,
  input  logic [DATA_W-1:0]     bf_outa_im,
  input  logic [DATA_W-1:0]     bf_outb_re,
  input  logic [DATA_W-1:0]     bf_outb_im,
  input  logic                  bf_done
);

  localparam int TMO_W = $clog2(BF_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [N_LOG2-1:0]     s_q, s_d;
  logic [N_LOG2-2:0]     j_q, j_d;
  logic [TMO_W-1:0]      tmo_q;
  logic                  last_j, last_s;
  logic [N_LOG2-1:0]     addr_a_d, addr_b_d;
  logic [N_LOG2-2:0]     tw_addr_d;

  logic                  busy_q, done_q, err_q, ram_re_q, ram_we_q, bf_en_q;
  logic [N_LOG2-1:0]     ram_addr_a_q, ram_addr_b_q;
  logic [N_LOG2-2:0]     tw_addr_q;
  logic [2*DATA_W-1:0]   ram_wd_a_q, ram_wd_b_q;
  logic [DATA_W-1:0]     bf_a_re_q, bf_a_im_q, bf_b_re_q, bf_b_im_q;
  logic [TW_W-1:0]       bf_c_re_q, bf_c_im_q;

  // a = ((j>>s)<<(s+1)) | k with k = j & (2^s-1); b = a | 2^s; twiddle = k << (N_LOG2-1-s)
  function automatic logic [N_LOG2-1:0] half_f(input logic [N_LOG2-1:0] s);
    return N_LOG2'(1) << s;
  endfunction

  function automatic logic [N_LOG2-1:0] k_f(input logic [N_LOG2-1:0] s,
                                            input logic [N_LOG2-2:0] j);
    return {1'b0, j} & (half_f(s) - N_LOG2'(1));
  endfunction

  always_comb begin
    last_j = (j_q == '1);
    last_s = (s_q == N_LOG2'(N_LOG2 - 1));
    s_d    = s_q;
    j_d    = j_q;
    if (state_q == S_IDLE) begin
      s_d = '0;
      j_d = '0;
    end else if (last_j) begin
      s_d = s_q + 1'b1;
      j_d = '0;
    end else begin
      j_d = j_q + 1'b1;
    end
    addr_a_d  = ((({1'b0, j_d}) >> s_d) << (s_d + 1'b1)) | k_f(s_d, j_d);
    addr_b_d  = addr_a_d | half_f(s_d);
    tw_addr_d = (N_LOG2 - 1)'(k_f(s_d, j_d) << (N_LOG2 - 1 - int'(s_d)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      s_q          <= '0;
      j_q          <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      bf_en_q      <= 1'b0;
      ram_addr_a_q <= '0;
      ram_addr_b_q <= '0;
      tw_addr_q    <= '0;
      ram_wd_a_q   <= '0;
      ram_wd_b_q   <= '0;
      bf_a_re_q    <= '0;
      bf_a_im_q    <= '0;
      bf_b_re_q    <= '0;
      bf_b_im_q    <= '0;
      bf_c_re_q    <= '0;
      bf_c_im_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            err_q        <= 1'b0;
            s_q          <= s_d;
            j_q          <= j_d;
            ram_addr_a_q <= addr_a_d;
            ram_addr_b_q <= addr_b_d;
            tw_addr_q    <= tw_addr_d;
            ram_re_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_RD;
          end
        end
        S_RD: begin
          ram_re_q <= 1'b0;
          state_q  <= S_LAT;
        end
        S_LAT: begin
          bf_a_re_q <= ram_rd_a[DATA_W-1:0];
          bf_a_im_q <= ram_rd_a[2*DATA_W-1:DATA_W];
          bf_b_re_q <= ram_rd_b[DATA_W-1:0];
          bf_b_im_q <= ram_rd_b[2*DATA_W-1:DATA_W];
          bf_c_re_q <= tw_rd[TW_W-1:0];
          bf_c_im_q <= tw_rd[2*TW_W-1:TW_W];
          bf_en_q   <= 1'b1;
          tmo_q     <= '0;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (bf_done) begin
            ram_wd_a_q <= {bf_outa_im, bf_outa_re};
            ram_wd_b_q <= {bf_outb_im, bf_outb_re};
            bf_en_q    <= 1'b0;
            ram_we_q   <= 1'b1;
            state_q    <= S_WB;
          end else if (tmo_q == TMO_W'(BF_TMO - 1)) begin
            // This is the BF_TMO-th EXEC cycle without completion: abandon the run.
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            bf_en_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WB: begin
          ram_we_q <= 1'b0;
          if (last_j && last_s) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            s_q          <= s_d;
            j_q          <= j_d;
            ram_addr_a_q <= addr_a_d;
            ram_addr_b_q <= addr_b_d;
            tw_addr_q    <= tw_addr_d;
            ram_re_q     <= 1'b1;
            state_q      <= S_RD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign stage      = s_q;
  assign ram_addr_a = ram_addr_a_q;
  assign ram_addr_b = ram_addr_b_q;
  assign ram_re     = ram_re_q;
  assign ram_we     = ram_we_q;
  assign ram_wd_a   = ram_wd_a_q;
  assign ram_wd_b   = ram_wd_b_q;
  assign tw_addr    = tw_addr_q;
  assign bf_en      = bf_en_q;
  assign bf_a_re    = bf_a_re_q;
  assign bf_a_im    = bf_a_im_q;
  assign bf_b_re    = bf_b_re_q;
  assign bf_b_im    = bf_b_im_q;
  assign bf_c_re    = bf_c_re_q;
  assign bf_c_im    = bf_c_im_q;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched at N=8: RAM/ROM/butterfly models plus a write-back scoreboard.
module tb_fft_bfly_sched;

  localparam int NL = 3;
  localparam int DW = 24;
  localparam int TW = 16;
  localparam int TMO = 16;
  localparam int N = 8;
  localparam int LAT_L = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, err;
  logic [NL-1:0]   stage, ram_addr_a, ram_addr_b;
  logic            ram_re, ram_we;
  logic [2*DW-1:0] ram_rd_a, ram_rd_b, ram_wd_a, ram_wd_b;
  logic [NL-2:0]   tw_addr;
  logic [2*TW-1:0] tw_rd;
  logic            bf_en, bf_done;
  logic [DW-1:0]   bf_a_re, bf_a_im, bf_b_re, bf_b_im;
  logic [TW-1:0]   bf_c_re, bf_c_im;
  logic [DW-1:0]   bf_outa_re, bf_outa_im, bf_outb_re, bf_outb_im;

  logic [2*DW-1:0] mem [N];
  logic            load_imp = 1'b0;
  logic            bf_resp = 1'b1;
  int              ecnt = 0;
  logic [NL-2:0]   tw_seen = '0;

  typedef struct {
    logic [NL-1:0]   a;
    logic [NL-1:0]   b;
    logic [NL-2:0]   tw;
    logic [2*DW-1:0] wa;
    logic [2*DW-1:0] wb;
  } wb_t;
  wb_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  fft_bfly_sched #(.N_LOG2(NL), .DATA_W(DW), .TW_W(TW), .BF_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .stage(stage), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rd_a(ram_rd_a), .ram_rd_b(ram_rd_b),
    .ram_wd_a(ram_wd_a), .ram_wd_b(ram_wd_b), .tw_addr(tw_addr), .tw_rd(tw_rd),
    .bf_en(bf_en), .bf_a_re(bf_a_re), .bf_a_im(bf_a_im), .bf_b_re(bf_b_re),
    .bf_b_im(bf_b_im), .bf_c_re(bf_c_re), .bf_c_im(bf_c_im),
    .bf_outa_re(bf_outa_re), .bf_outa_im(bf_outa_im),
    .bf_outb_re(bf_outb_re), .bf_outb_im(bf_outb_im), .bf_done(bf_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // W_8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), scaled by 2^13, packed {im,re}
  function automatic logic [2*TW-1:0] rom(input logic [NL-2:0] k);
    logic signed [TW-1:0] re, im;
    case (k)
      2'd0:    begin re = 16'sd8192;  im = 16'sd0;     end
      2'd1:    begin re = 16'sd5793;  im = -16'sd5793; end
      2'd2:    begin re = 16'sd0;     im = -16'sd8192; end
      default: begin re = -16'sd5793; im = -16'sd5793; end
    endcase
    return {im, re};
  endfunction

  // Returns {outb, outa}, each {im,re}: outa = a + b*w, outb = a - b*w
  function automatic logic [4*DW-1:0] bfly(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                           input logic [2*TW-1:0] w);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[DW-1:0]));
    ai = longint'($signed(a[2*DW-1:DW]));
    br = longint'($signed(b[DW-1:0]));
    bi = longint'($signed(b[2*DW-1:DW]));
    wr = longint'($signed(w[TW-1:0]));
    wi = longint'($signed(w[2*TW-1:TW]));
    pr = (br * wr - bi * wi) >>> 13;
    pi = (br * wi + bi * wr) >>> 13;
    return {DW'(ai - pi), DW'(ar - pr), DW'(ai + pi), DW'(ar + pr)};
  endfunction

  assign {bf_outb_im, bf_outb_re, bf_outa_im, bf_outa_re} =
    bfly({bf_a_im, bf_a_re}, {bf_b_im, bf_b_re}, {bf_c_im, bf_c_re});
  assign bf_done = bf_resp && bf_en && (ecnt == LAT_L);

  always @(posedge clk) begin
    ecnt <= bf_en ? ecnt + 1 : 0;
    if (ram_re) begin
      ram_rd_a <= mem[ram_addr_a];
      ram_rd_b <= mem[ram_addr_b];
    end
    tw_rd <= rom(tw_addr);
    if (load_imp) begin
      for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? 48'd4096 : 48'd0;
    end else if (ram_we) begin
      mem[ram_addr_a] <= ram_wd_a;
      mem[ram_addr_b] <= ram_wd_b;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (ram_re) tw_seen = tw_addr;
      if (ram_we) begin
        chk("re_we_overlap", {63'd0, ram_re}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", {63'd0, ram_we}, 64'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_addr_a", {61'd0, ram_addr_a}, {61'd0, e.a});
          chk("wb_addr_b", {61'd0, ram_addr_b}, {61'd0, e.b});
          chk("wb_tw", {62'd0, tw_seen}, {62'd0, e.tw});
          chk("wb_data_a", {16'd0, ram_wd_a}, {16'd0, e.wa});
          chk("wb_data_b", {16'd0, ram_wd_b}, {16'd0, e.wb});
        end
      end
    end
  end

  // Reference in-place DIT walk over groups of size m = 2^(s+1) with an impulse input.
  task automatic push_ref();
    logic [2*DW-1:0] rm [N];
    logic [4*DW-1:0] r;
    wb_t             e;
    for (int unsigned i = 0; i < N; i++) rm[i] = (i == 0) ? 48'd4096 : 48'd0;
    for (int unsigned s = 0; s < NL; s++) begin
      int unsigned half, m;
      half = 1 << s;
      m    = half * 2;
      for (int unsigned g = 0; g < N; g += m) begin
        for (int unsigned k = 0; k < half; k++) begin
          e.a  = NL'(g + k);
          e.b  = NL'(g + k + half);
          e.tw = (NL-1)'(k * (N / m));
          r    = bfly(rm[e.a], rm[e.b], rom(e.tw));
          e.wa = r[2*DW-1:0];
          e.wb = r[4*DW-1:2*DW];
          rm[e.a] = e.wa;
          rm[e.b] = e.wb;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_fft(input bit disturb);
    int cyc, lows;
    @(negedge clk) load_imp = 1'b1;
    @(negedge clk) load_imp = 1'b0;
    push_ref();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc  = 1;
    lows = 0;
    chk("err_cleared", {63'd0, err}, 64'd0);
    while (!done && cyc < 200) begin
      if (!busy) lows++;
      if (disturb && cyc == 40) start = 1'b1;
      if (disturb && cyc == 41) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'd85);
    chk("busy_gaps", 64'(lows), 64'd0);
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_width", {63'd0, done}, 64'd0);
    chk("wb_count", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < N; i++) chk("bin", {16'd0, mem[i]}, 64'd4096);
    repeat (6) @(negedge clk);
    chk("idle_after_run", {62'd0, busy, ram_re}, 64'd0);
  endtask

  initial begin
    int en_cnt, seen_done, cyc;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {63'd0, |{busy, done, err, stage, ram_addr_a, ram_addr_b, ram_re, ram_we,
        ram_wd_a, ram_wd_b, tw_addr, bf_en, bf_a_re, bf_a_im, bf_b_re, bf_b_im,
        bf_c_re, bf_c_im}}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_fft(1'b0);
    run_fft(1'b1);

    // Butterfly never completes.
    bf_resp = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    en_cnt = 0;
    seen_done = 0;
    cyc = 1;
    while ((busy || cyc == 1) && cyc < 100) begin
      if (bf_en) en_cnt++;
      if (done) seen_done = 1;
      @(negedge clk);
      cyc++;
    end
    chk("tmo_exec_cycles", 64'(en_cnt), 64'(TMO));
    chk("tmo_err", {63'd0, err}, 64'd1);
    chk("tmo_busy", {62'd0, busy, bf_en}, 64'd0);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", {62'd0, err, done}, 64'd2);
    chk("tmo_no_done", 64'(seen_done), 64'd0);
    bf_resp = 1'b1;
    run_fft(1'b0);

    // Reset during stage-1 EXEC.
    @(negedge clk) load_imp = 1'b1;
    @(negedge clk) load_imp = 1'b0;
    push_ref();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (stage == 1 && bf_en) break;
      @(negedge clk);
    end
    chk("reach_stage1_exec", {63'd0, (stage == 1) && bf_en}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midrun_rst_outputs", {63'd0, |{busy, done, err, stage, ram_addr_a, ram_addr_b, ram_re,
        ram_we, ram_wd_a, ram_wd_b, tw_addr, bf_en, bf_a_re, bf_a_im, bf_b_re, bf_b_im,
        bf_c_re, bf_c_im}}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {61'd0, busy, ram_re, done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
In-place radix-2 DIT FFT sequencer, i.e. the initiator that drives the butterfly datapath. It walks every stage, group and butterfly of an N-point transform. For each butterfly it reads the operand pair from a dual-port sample RAM and fetches the twiddle from a ROM. It presents both to the butterfly unit, holds them until the unit flags completion, then writes both results back to the same addresses. Samples are already in bit-reversed order in RAM when start is pulsed.

Parameters:
N_LOG2, 8, log2 of FFT length N (N = 2^N_LOG2, N_LOG2 >= 2)
DATA_W, 24, sample component width (signed)
TW_W, 16, twiddle component width (signed, scaled 2^13)
BF_TMO, 16, max EXEC cycles waiting for bf_done before error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to run a full transform; ignored unless in IDLE
busy  out  1  high from first RD through last WB
done  out  1  one-cycle pulse after final write-back
err  out  1  sticky butterfly timeout flag, cleared by next accepted start
stage  out  N_LOG2  current stage index s (0..N_LOG2-1), debug
ram_addr_a  out  N_LOG2  port A address (a operand)
ram_addr_b  out  N_LOG2  port B address (b operand)
ram_re  out  1  read strobe, both ports
ram_we  out  1  write strobe, both ports
ram_rd_a  in  2*DATA_W  port A read data {im,re}, valid 1 cycle after ram_re
ram_rd_b  in  2*DATA_W  port B read data {im,re}
ram_wd_a  out  2*DATA_W  port A write data {outa_im,outa_re}
ram_wd_b  out  2*DATA_W  port B write data {outb_im,outb_re}
tw_addr  out  N_LOG2-1  twiddle ROM index k' (W_N^k')
tw_rd  in  2*TW_W  twiddle {im,re}, valid 1 cycle after tw_addr
bf_en  out  1  butterfly enable, held high through EXEC
bf_a_re, bf_a_im, bf_b_re, bf_b_im  out  DATA_W each  registered operands
bf_c_re, bf_c_im  out  TW_W each  registered twiddle
bf_outa_re, bf_outa_im, bf_outb_re, bf_outb_im  in  DATA_W each  butterfly results
bf_done  in  1  butterfly completion flag

Behaviour:
- Reset: FSM=IDLE and all counters 0. Every output is 0 (busy, done, err, ram_re, ram_we, bf_en, all addresses, data and operand registers).
- Counters:
  - stage s: 0..N_LOG2-1.
  - butterfly j: 0..N/2-1 within each stage.
  - half = 2^s; k = j & (half-1).
  - a = ((j>>s) << (s+1)) | k; b = a | half.
  - tw_addr = k << (N_LOG2-1-s).
- States:
  - IDLE: done=0. When start=1: err<=0, s<=0, j<=0, go to RD.
  - RD: ram_addr_a=a, ram_addr_b=b, tw_addr driven, ram_re=1, busy=1 -> LAT.
  - LAT: at the end of this cycle, latch ram_rd_a/b and tw_rd into the bf_* operand registers -> EXEC.
  - EXEC: bf_en=1; operands stable; timeout counter increments.
    - If bf_done=1: capture bf_out* into ram_wd_a/b -> WB.
    - Else if the counter reaches BF_TMO: err<=1, busy<=0 -> IDLE (no done, no write).
  - WB: ram_we=1 with ram_addr_a=a, ram_addr_b=b, bf_en=0.
    - If j=N/2-1 and s=N_LOG2-1 -> DONE.
    - Else if j=N/2-1: s<=s+1, j<=0 -> RD.
    - Else j<=j+1 -> RD.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- bf_en stays high every EXEC cycle, because the butterfly pipeline is clock-enabled by it. It drops in the WB cycle.
- ram_re and ram_we are never high in the same cycle. Addresses are held in LAT and EXEC.
- Timing: with bf_done arriving L cycles after the first EXEC cycle, each butterfly takes L+4 cycles. Start-to-done = 1 + N_LOG2*(N/2)*(L+4) cycles.
- start while busy or in DONE: ignored, no state change.
- bf_done outside EXEC: ignored.
- Reset mid-operation: immediate return to IDLE with outputs 0. No partial write is issued after rst deasserts.
- Data widths pass through unchanged; no scaling in this block.

Test Plan:
- N_LOG2=3, butterfly model with L=3 and unity twiddles, start pulse -> 12 write-backs, done exactly 85 cycles after the start cycle, busy high throughout, done high 1 cycle.
- Address sequence for N_LOG2=3:
  - Stage 0 pairs (0,1),(2,3),(4,5),(6,7) with tw_addr 0.
  - Stage 1 pairs (0,2),(1,3),(4,6),(5,7) with tw_addr 0,2,0,2.
  - Stage 2 pairs (0,4)..(3,7) with tw_addr 0,1,2,3.
- Real butterfly plus RAM model: load bit-reversed impulse x[0]=4096 -> all 8 bins equal 4096+j0 after done.
- bf_done never asserted, BF_TMO=16 -> err=1 after 16 EXEC cycles, busy=0, no ram_we, done stays 0. A following start clears err.
- start pulsed again mid-run and during the DONE cycle -> ignored: address sequence and done timing identical to the undisturbed run.
- rst asserted during EXEC of stage 1 -> all outputs 0 immediately. After release no ram_we occurs until a new start.
